// File: rtl/raster_pkg.sv
// Shared opcodes, coordinate width, FSM states and command record for the raster sequencer.
package raster_pkg;

  localparam int unsigned COORD_W = 3;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_LINE  = 2'b10;
  localparam logic [1:0] CMD_RECT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIXEL,
    ST_LINE,
    ST_RECT,
    ST_CLEAR,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]         cmd;
    logic               clear;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } cmd_t;

  // Sum one bit wider than a coordinate so overflow clips to the edge instead of wrapping.
  function automatic logic [COORD_W-1:0] clip_sum(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W] ? '1 : s[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/raster_sequencer_if.sv
// Command handshake and framebuffer write bundle; slave is the sequencer side.
interface raster_sequencer_if;

  logic                             in_valid;
  logic                             in_ready;
  logic [1:0]                       in_cmd;
  logic                             in_clear;
  logic [raster_pkg::COORD_W-1:0]   in_x1;
  logic [raster_pkg::COORD_W-1:0]   in_y1;
  logic [raster_pkg::COORD_W-1:0]   in_x2;
  logic [raster_pkg::COORD_W-1:0]   in_y2;
  logic [raster_pkg::COORD_W-1:0]   in_width;
  logic [raster_pkg::COORD_W-1:0]   in_height;
  logic                             fb_we;
  logic [raster_pkg::COORD_W-1:0]   fb_x;
  logic [raster_pkg::COORD_W-1:0]   fb_y;
  logic                             fb_data;
  logic                             fb_ready;
  logic                             busy;
  logic                             done;

  modport master (
    output in_valid, in_cmd, in_clear, in_x1, in_y1, in_x2, in_y2, in_width, in_height, fb_ready,
    input  in_ready, fb_we, fb_x, fb_y, fb_data, busy, done
  );

  modport slave (
    input  in_valid, in_cmd, in_clear, in_x1, in_y1, in_x2, in_y2, in_width, in_height, fb_ready,
    output in_ready, fb_we, fb_x, fb_y, fb_data, busy, done
  );

endinterface

// File: rtl/raster_line_stepper.sv
// Integer Bresenham iterator: load captures endpoints, step advances one pixel, last flags (x2,y2).
module raster_line_stepper
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  typedef logic signed [5:0] err_t;

  err_t               err, dx, dy, e2, err_nxt, ldx, ldy;
  logic [COORD_W-1:0] xe, ye;
  logic               sx_neg, sy_neg, step_x, step_y;

  always_comb begin
    ldx     = $signed({3'b000, ((x2 >= x1) ? (x2 - x1) : (x1 - x2))});
    ldy     = -$signed({3'b000, ((y2 >= y1) ? (y2 - y1) : (y1 - y2))});
    e2      = err <<< 1;
    step_x  = (e2 >= dy);
    step_y  = (e2 <= dx);
    err_nxt = err + (step_x ? dy : err_t'(0)) + (step_y ? dx : err_t'(0));
    last    = (x == xe) && (y == ye);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      xe     <= '0;
      ye     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      x      <= x1;
      y      <= y1;
      xe     <= x2;
      ye     <= y2;
      dx     <= ldx;
      dy     <= ldy;
      err    <= ldx + ldy;
      sx_neg <= (x2 < x1);
      sy_neg <= (y2 < y1);
    end else if (step) begin
      err <= err_nxt;
      if (step_x) x <= sx_neg ? x - 1'b1 : x + 1'b1;
      if (step_y) y <= sy_neg ? y - 1'b1 : y + 1'b1;
    end
  end

endmodule

// File: rtl/raster_sequencer.sv
// 8x8 raster command sequencer (pixel/clear/line/rect) issuing one framebuffer write per ready cycle.
// Build option RASTER_CMD_QUEUE_EN: 2-entry command FIFO instead of single-command acceptance.
module raster_sequencer
  import raster_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  raster_sequencer_if.slave bus
);

  localparam logic [COORD_W-1:0] MAX_C = '1;

  state_t             state, state_nxt;
  cmd_t               in_c, ld_c;
  logic               fire, load, held;
  logic [COORD_W-1:0] cur_x, cur_y, x_start, x_end, y_end;
  logic [COORD_W-1:0] cur_x_nxt, cur_y_nxt, x_start_nxt, x_end_nxt, y_end_nxt;
  logic               ln_load, ln_step, ln_last;
  logic [COORD_W-1:0] ln_x, ln_y;

  assign in_c = '{cmd: bus.in_cmd, clear: bus.in_clear, x1: bus.in_x1, y1: bus.in_y1,
                  x2: bus.in_x2, y2: bus.in_y2, width: bus.in_width, height: bus.in_height};

`ifdef RASTER_CMD_QUEUE_EN
  cmd_t       q_mem [2];
  logic       q_wr, q_rd, q_push, q_pop, q_bypass;
  logic [1:0] q_cnt;

  // An idle sequencer with an empty FIFO takes the command directly, skipping the FIFO.
  assign bus.in_ready = (q_cnt != 2'd2);
  assign fire         = bus.in_valid && bus.in_ready;
  assign q_bypass     = (state == ST_IDLE) && (q_cnt == 2'd0);
  assign q_pop        = (state == ST_IDLE) && (q_cnt != 2'd0);
  assign q_push       = fire && (in_c.cmd != CMD_NOP) && !q_bypass;
  assign load         = q_pop || (fire && (in_c.cmd != CMD_NOP) && q_bypass);
  assign ld_c         = q_pop ? q_mem[q_rd] : in_c;
  assign held         = (q_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr] <= in_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_wr  <= 1'b0;
      q_rd  <= 1'b0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wr <= ~q_wr;
      if (q_pop)  q_rd <= ~q_rd;
      if (q_push && !q_pop)      q_cnt <= q_cnt + 2'd1;
      else if (q_pop && !q_push) q_cnt <= q_cnt - 2'd1;
    end
  end
`else
  assign bus.in_ready = (state == ST_IDLE);
  assign fire         = bus.in_valid && bus.in_ready;
  assign load         = fire && (in_c.cmd != CMD_NOP);
  assign ld_c         = in_c;
  assign held         = 1'b0;
`endif

  raster_line_stepper u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ln_load),
    .step  (ln_step),
    .x1    (ld_c.x1),
    .y1    (ld_c.y1),
    .x2    (ld_c.x2),
    .y2    (ld_c.y2),
    .x     (ln_x),
    .y     (ln_y),
    .last  (ln_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cur_x   <= '0;
      cur_y   <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else begin
      state   <= state_nxt;
      cur_x   <= cur_x_nxt;
      cur_y   <= cur_y_nxt;
      x_start <= x_start_nxt;
      x_end   <= x_end_nxt;
      y_end   <= y_end_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_x_nxt   = cur_x;
    cur_y_nxt   = cur_y;
    x_start_nxt = x_start;
    x_end_nxt   = x_end;
    y_end_nxt   = y_end;
    ln_load     = 1'b0;
    ln_step     = 1'b0;
    bus.fb_we   = 1'b0;
    bus.done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          cur_x_nxt   = ld_c.x1;
          cur_y_nxt   = ld_c.y1;
          x_start_nxt = ld_c.x1;
          x_end_nxt   = clip_sum(ld_c.x1, ld_c.width);
          y_end_nxt   = clip_sum(ld_c.y1, ld_c.height);
          case (ld_c.cmd)
            CMD_PIXEL: begin
              if (ld_c.clear) begin
                state_nxt = ST_CLEAR;
                cur_x_nxt = '0;
                cur_y_nxt = '0;
              end else begin
                state_nxt = ST_PIXEL;
              end
            end
            CMD_LINE: begin
              state_nxt = ST_LINE;
              ln_load   = 1'b1;
            end
            CMD_RECT: state_nxt = ST_RECT;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_PIXEL: begin
        bus.fb_we = 1'b1;
        if (bus.fb_ready) state_nxt = ST_DONE;
      end
      ST_CLEAR: begin
        bus.fb_we = 1'b1;
        if (bus.fb_ready) begin
          if (cur_x == MAX_C && cur_y == MAX_C) begin
            state_nxt = ST_DONE;
          end else begin
            cur_x_nxt = cur_x + 1'b1;
            if (cur_x == MAX_C) cur_y_nxt = cur_y + 1'b1;
          end
        end
      end
      ST_RECT: begin
        bus.fb_we = 1'b1;
        if (bus.fb_ready) begin
          if (cur_x == x_end) begin
            if (cur_y == y_end) begin
              state_nxt = ST_DONE;
            end else begin
              cur_x_nxt = x_start;
              cur_y_nxt = cur_y + 1'b1;
            end
          end else begin
            cur_x_nxt = cur_x + 1'b1;
          end
        end
      end
      ST_LINE: begin
        bus.fb_we = 1'b1;
        if (bus.fb_ready) begin
          if (ln_last) state_nxt = ST_DONE;
          else         ln_step   = 1'b1;
        end
      end
      ST_DONE: begin
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.fb_x    = (state == ST_LINE) ? ln_x : cur_x;
  assign bus.fb_y    = (state == ST_LINE) ? ln_y : cur_y;
  assign bus.fb_data = (state == ST_PIXEL) || (state == ST_LINE) || (state == ST_RECT);
  assign bus.busy    = (state != ST_IDLE) || held || load;

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer: directed cases plus randomized commands against a pixel-list model.
module tb_raster_sequencer;
  import raster_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raster_sequencer_if bus();
  raster_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int obs_key[$];
  int obs_cyc[$];
  int done_cyc[$];
  int exp_key[$];

  logic       smp_ready, smp_busy, smp_we, smp_done, smp_d, acc_busy;
  logic [2:0] smp_x, smp_y;

  logic [1:0] p_cmd = 2'b00;
  logic       p_clr = 1'b0;
  logic [2:0] p_x1 = '0, p_y1 = '0, p_x2 = '0, p_y2 = '0, p_w = '0, p_h = '0;

  function automatic int key(input int x, input int y, input int d);
    return x * 100 + y * 10 + d;
  endfunction

  function automatic logic pick(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Appends the pixels a command must produce, in order, straight from the drawing rules.
  function automatic void model(input int c, input int clr, input int x1, input int y1,
                                input int x2, input int y2, input int w, input int h);
    int xe, ye, x, y, dx, dy, sx, sy, err, e2;
    if (c == 1 && clr != 0) begin
      for (int yy = 0; yy < 8; yy++)
        for (int xx = 0; xx < 8; xx++) exp_key.push_back(key(xx, yy, 0));
    end else if (c == 1) begin
      exp_key.push_back(key(x1, y1, 1));
    end else if (c == 3) begin
      xe = (x1 + w > 7) ? 7 : x1 + w;
      ye = (y1 + h > 7) ? 7 : y1 + h;
      for (int yy = y1; yy <= ye; yy++)
        for (int xx = x1; xx <= xe; xx++) exp_key.push_back(key(xx, yy, 1));
    end else if (c == 2) begin
      x = x1; y = y1;
      dx = (x2 > x1) ? x2 - x1 : x1 - x2;
      dy = (y2 > y1) ? y1 - y2 : y2 - y1;
      sx = (x1 < x2) ? 1 : -1;
      sy = (y1 < y2) ? 1 : -1;
      err = dx + dy;
      for (int guard = 0; guard < 32; guard++) begin
        exp_key.push_back(key(x, y, 1));
        if (x == x2 && y == y2) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
  endfunction

  // One cycle: drive at the falling edge, sample 1 time unit later, log accepted writes and done pulses.
  task automatic tick(input logic v, input logic rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_cmd    = p_cmd;
    bus.in_clear  = p_clr;
    bus.in_x1     = p_x1;
    bus.in_y1     = p_y1;
    bus.in_x2     = p_x2;
    bus.in_y2     = p_y2;
    bus.in_width  = p_w;
    bus.in_height = p_h;
    bus.fb_ready  = rdy;
    #1;
    cyc++;
    smp_ready = bus.in_ready;
    smp_busy  = bus.busy;
    smp_we    = bus.fb_we;
    smp_done  = bus.done;
    smp_x     = bus.fb_x;
    smp_y     = bus.fb_y;
    smp_d     = bus.fb_data;
    if (bus.fb_we && bus.fb_ready) begin
      obs_key.push_back(key(bus.fb_x, bus.fb_y, bus.fb_data));
      obs_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
  endtask

  task automatic set_cmd(input int c, input int clr, input int x1, input int y1,
                         input int x2, input int y2, input int w, input int h);
    p_cmd = 2'(c); p_clr = 1'(clr);
    p_x1 = 3'(x1); p_y1 = 3'(y1); p_x2 = 3'(x2); p_y2 = 3'(y2); p_w = 3'(w); p_h = 3'(h);
  endtask

  // Issues one command from idle and runs until its done pulse (bounded).
  task automatic run_cmd(input int c, input int clr, input int x1, input int y1, input int x2,
                         input int y2, input int w, input int h, input int pct, output int acc);
    obs_key.delete(); obs_cyc.delete(); done_cyc.delete(); exp_key.delete();
    model(c, clr, x1, y1, x2, y2, w, h);
    set_cmd(c, clr, x1, y1, x2, y2, w, h);
    tick(1'b1, pick(pct));
    acc = cyc;
    acc_busy = smp_busy;
    n_tests++;
    if (smp_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept: in_ready=%b required 1", smp_ready);
    end
    for (int k = 0; k < 500 && done_cyc.size() == 0; k++) tick(1'b0, pick(pct));
    n_tests++;
    if (done_cyc.size() != 1) begin
      n_fail++; $display("FAIL done_seen: got %0d done pulses required 1", done_cyc.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    rst_n = 1'b1;
    tick(1'b0, 1'b1);
    n_tests++; if (smp_we !== 1'b0)   begin n_fail++; $display("FAIL rst_we: got %b required 0", smp_we); end
    n_tests++; if (smp_x !== 3'd0)    begin n_fail++; $display("FAIL rst_x: got %0d required 0", smp_x); end
    n_tests++; if (smp_y !== 3'd0)    begin n_fail++; $display("FAIL rst_y: got %0d required 0", smp_y); end
    n_tests++; if (smp_d !== 1'b0)    begin n_fail++; $display("FAIL rst_data: got %b required 0", smp_d); end
    n_tests++; if (smp_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", smp_done); end
    n_tests++; if (smp_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", smp_busy); end
    n_tests++; if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", smp_ready); end
  endtask

  task automatic test_pixel();
    int acc;
    run_cmd(1, 0, 3, 5, 0, 0, 0, 0, 100, acc);
    n_tests++; if (acc_busy !== 1'b1) begin n_fail++; $display("FAIL pixel_busy_acc: got %b required 1", acc_busy); end
    n_tests++;
    if (obs_key.size() != 1 || obs_key[0] != key(3, 5, 1)) begin
      n_fail++; $display("FAIL pixel_write: got %0d writes first=%0d required 1 write 351", obs_key.size(),
                         (obs_key.size() > 0) ? obs_key[0] : -1);
    end
    n_tests++;
    if (obs_cyc.size() < 1 || obs_cyc[0] != acc + 1) begin
      n_fail++; $display("FAIL pixel_latency: got cycle %0d required %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, acc + 1);
    end
    n_tests++;
    if (done_cyc.size() < 1 || done_cyc[0] != acc + 2) begin
      n_fail++; $display("FAIL pixel_done_cycle: got %0d required %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, acc + 2);
    end
  endtask

  task automatic test_clear();
    int acc;
    run_cmd(1, 1, 2, 2, 0, 0, 0, 0, 100, acc);
    n_tests++;
    if (obs_key.size() != 64) begin n_fail++; $display("FAIL clear_count: got %0d required 64", obs_key.size()); end
    foreach (exp_key[i]) if (i < obs_key.size()) begin
      n_tests++;
      if (obs_key[i] !== exp_key[i] || obs_cyc[i] !== acc + 1 + i) begin
        n_fail++; $display("FAIL clear_px[%0d]: got %0d@%0d required %0d@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], acc + 1 + i);
      end
    end
    n_tests++;
    if (done_cyc.size() < 1 || done_cyc[0] != acc + 65) begin
      n_fail++; $display("FAIL clear_done_cycle: got %0d required %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, acc + 65);
    end
    tick(1'b0, 1'b1);
    n_tests++; if (smp_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b required 0", smp_done); end
    n_tests++; if (smp_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b required 0", smp_busy); end
  endtask

  task automatic test_shapes();
    int acc;
    int tbl[4][7] = '{'{3, 6, 1, 0, 0, 3, 1}, '{2, 0, 0, 7, 3, 0, 0},
                      '{2, 4, 4, 4, 4, 0, 0}, '{3, 5, 6, 0, 0, 7, 7}};
    for (int t = 0; t < 4; t++) begin
      run_cmd(tbl[t][0], 0, tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4], tbl[t][5], tbl[t][6], 100, acc);
      n_tests++;
      if (obs_key.size() != exp_key.size()) begin
        n_fail++; $display("FAIL shape%0d_count: got %0d required %0d", t, obs_key.size(), exp_key.size());
      end
      foreach (exp_key[i]) if (i < obs_key.size()) begin
        n_tests++;
        if (obs_key[i] !== exp_key[i]) begin
          n_fail++; $display("FAIL shape%0d_px[%0d]: got %0d required %0d", t, i, obs_key[i], exp_key[i]);
        end
      end
    end
  endtask

  task automatic test_nop();
    obs_key.delete(); done_cyc.delete();
    set_cmd(0, 0, 1, 1, 1, 1, 1, 1);
    tick(1'b1, 1'b1);
    n_tests++; if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready: got %b required 1", smp_ready); end
    repeat (6) tick(1'b0, 1'b1);
    n_tests++;
    if (obs_key.size() != 0 || done_cyc.size() != 0) begin
      n_fail++; $display("FAIL nop_effect: got %0d writes %0d done required 0 0", obs_key.size(), done_cyc.size());
    end
  endtask

  task automatic test_stall();
    obs_key.delete(); done_cyc.delete(); exp_key.delete();
    model(3, 0, 2, 2, 0, 0, 2, 1);
    set_cmd(3, 0, 2, 2, 0, 0, 2, 1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      n_tests++;
      if (smp_we !== 1'b1 || key(smp_x, smp_y, smp_d) != key(3, 2, 1)) begin
        n_fail++; $display("FAIL stall_hold%0d: got we=%b %0d required we=1 321", k, smp_we, key(smp_x, smp_y, smp_d));
      end
    end
    for (int k = 0; k < 50 && done_cyc.size() == 0; k++) tick(1'b0, 1'b1);
    n_tests++;
    if (obs_key.size() != exp_key.size() || done_cyc.size() != 1) begin
      n_fail++; $display("FAIL stall_count: got %0d writes %0d done required %0d 1", obs_key.size(), done_cyc.size(), exp_key.size());
    end
    foreach (exp_key[i]) if (i < obs_key.size()) begin
      n_tests++;
      if (obs_key[i] !== exp_key[i]) begin
        n_fail++; $display("FAIL stall_px[%0d]: got %0d required %0d", i, obs_key[i], exp_key[i]);
      end
    end
  endtask

  task automatic test_random();
    int acc, c, clr;
    for (int n = 0; n < 30; n++) begin
      c   = int'($urandom_range(3, 1));
      clr = (c == 1 && $urandom_range(4, 0) == 0) ? 1 : 0;
      run_cmd(c, clr, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
              int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 70, acc);
      n_tests++;
      if (obs_key.size() != exp_key.size()) begin
        n_fail++; $display("FAIL rand%0d_count: cmd %0d got %0d required %0d", n, c, obs_key.size(), exp_key.size());
      end
      foreach (exp_key[i]) if (i < obs_key.size()) begin
        n_tests++;
        if (obs_key[i] !== exp_key[i]) begin
          n_fail++; $display("FAIL rand%0d_px[%0d]: got %0d required %0d", n, i, obs_key[i], exp_key[i]);
        end
      end
    end
  endtask

`ifdef RASTER_CMD_QUEUE_EN
  task automatic test_back_to_back();
    logic r[3];
    obs_key.delete(); done_cyc.delete(); exp_key.delete();
    model(1, 1, 0, 0, 0, 0, 0, 0);
    model(1, 0, 1, 2, 0, 0, 0, 0);
    model(3, 0, 5, 5, 0, 0, 1, 0);
    model(2, 0, 0, 7, 3, 4, 0, 0);
    set_cmd(1, 1, 0, 0, 0, 0, 0, 0); tick(1'b1, 1'b1);
    set_cmd(1, 0, 1, 2, 0, 0, 0, 0); tick(1'b1, 1'b1); r[0] = smp_ready;
    set_cmd(3, 0, 5, 5, 0, 0, 1, 0); tick(1'b1, 1'b1); r[1] = smp_ready;
    set_cmd(2, 0, 0, 7, 3, 4, 0, 0); tick(1'b1, 1'b1); r[2] = smp_ready;
    n_tests++;
    if (r[0] !== 1'b1 || r[1] !== 1'b1 || r[2] !== 1'b0) begin
      n_fail++; $display("FAIL queue_ready: got %b%b%b required 110", r[0], r[1], r[2]);
    end
    for (int k = 0; k < 200 && !smp_ready; k++) tick(1'b1, 1'b1);
    for (int k = 0; k < 400 && done_cyc.size() < 4; k++) tick(1'b0, 1'b1);
    n_tests++;
    if (obs_key.size() != exp_key.size() || done_cyc.size() != 4) begin
      n_fail++; $display("FAIL queue_count: got %0d writes %0d done required %0d 4", obs_key.size(), done_cyc.size(), exp_key.size());
    end
    foreach (exp_key[i]) if (i < obs_key.size()) begin
      n_tests++;
      if (obs_key[i] !== exp_key[i]) begin
        n_fail++; $display("FAIL queue_px[%0d]: got %0d required %0d", i, obs_key[i], exp_key[i]);
      end
    end
  endtask
`else
  task automatic test_back_to_back();
    set_cmd(1, 0, 4, 1, 0, 0, 0, 0);
    tick(1'b1, 1'b1);
    set_cmd(1, 0, 6, 6, 0, 0, 0, 0);
    tick(1'b1, 1'b1);
    n_tests++; if (smp_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_busy: got %b required 0", smp_ready); end
    tick(1'b1, 1'b1);
    n_tests++;
    if (smp_done !== 1'b1 || smp_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready_done: got done=%b ready=%b required 1 0", smp_done, smp_ready);
    end
    tick(1'b0, 1'b1);
    n_tests++; if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b required 1", smp_ready); end
  endtask
`endif

  task automatic test_mid_reset();
    set_cmd(1, 1, 0, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1);
    set_cmd(1, 0, 1, 1, 0, 0, 0, 0);
    repeat (2) tick(1'b1, 1'b1);
    repeat (6) tick(1'b0, 1'b1);
    rst_n = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_tests++;
    if (smp_we !== 1'b0 || smp_x !== 3'd0 || smp_y !== 3'd0 || smp_d !== 1'b0 || smp_done !== 1'b0 || smp_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got we=%b x=%0d y=%0d d=%b done=%b busy=%b required all 0",
                         smp_we, smp_x, smp_y, smp_d, smp_done, smp_busy);
    end
    n_tests++; if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", smp_ready); end
    rst_n = 1'b1;
    obs_key.delete(); done_cyc.delete();
    repeat (80) tick(1'b0, 1'b1);
    n_tests++;
    if (obs_key.size() != 0 || done_cyc.size() != 0) begin
      n_fail++; $display("FAIL midrst_queue: got %0d writes %0d done required 0 0", obs_key.size(), done_cyc.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_clear = 1'b0;
    bus.in_x1 = '0; bus.in_y1 = '0; bus.in_x2 = '0; bus.in_y2 = '0;
    bus.in_width = '0; bus.in_height = '0; bus.fb_ready = 1'b1;
    test_reset();
    test_pixel();
    test_clear();
    test_shapes();
    test_nop();
    test_stall();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
